// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Memory-access sequencer between the multi-cycle datapath and the data
// memory. It takes one load/store request at a time, forms the effective
// address ea = base + offset (modulo 2^ADDR_W), and drives the memory's
// addr/dataIn/MemRd/MemWr. The memory read is registered, so read data is
// consumed one cycle after MemRd. Byte stores are done as read-modify-write
// because the memory always writes the two bytes at addr and addr+1.
//
// Optional build macro:
//   LSU_ALIGN_CHECK_EN  when defined, LW/SW with an odd ea are rejected
//                       (done+err, no memory access). When undefined,
//                       odd word addresses go through to memory unchanged.
//
// Ports:
//   clk         in   system clock, all state on posedge
//   rst         in   synchronous active-high reset
//   start       in   request strobe, only sampled in IDLE
//   op          in   3-bit op: 000 LW, 001 LBU, 010 LB, 100 SW, 101 SB
//   base        in   base register value
//   offset      in   signed two's-complement offset
//   storeData   in   store data (SB uses bits [7:0])
//   busy        out  high in every non-IDLE state
//   done        out  one-cycle completion pulse
//   err         out  one-cycle pulse with done on illegal/rejected request
//   loadData    out  result of the last completed load, held otherwise
//   memAddr     out  memory address (always the latched ea)
//   memDataIn   out  memory write data (zero outside WR)
//   memDataOut  in   memory read data, valid the cycle after MemRd
//   MemRd       out  memory read enable
//   MemWr       out  memory write enable
//
// States:
//   state  | meaning
//   IDLE   | waiting for start; request latched on accept
//   RD     | MemRd issued at ea
//   WAIT   | memory read data valid; load result or RMW merge captured
//   WR     | MemWr issued at ea (store data or merged word)
//   DONE   | done pulse (err if request was illegal/rejected)
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  input  logic [DATA_W-1:0] storeData,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] loadData,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataIn,
  input  logic [DATA_W-1:0] memDataOut,
  output logic              MemRd,
  output logic              MemWr
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [2:0]        op_q;
  logic [DATA_W-1:0] sd_q;
  logic [ADDR_W-1:0] ea_q;
  logic [DATA_W-1:0] merge_q;
  logic              err_q;

  logic [ADDR_W-1:0] ea_in;
  logic              op_illegal;
  logic              reject;
  logic              accept;
  logic              op_q_is_load;
  logic [DATA_W-1:0] load_ext;

  // Carry out of the add is dropped on purpose: address space wraps.
  assign ea_in  = base + offset;
  assign accept = (state == S_IDLE) && start;

  always_comb begin
    op_illegal = 1'b1;
    case (op)
      OP_LW, OP_LBU, OP_LB, OP_SW, OP_SB: op_illegal = 1'b0;
      default:                            op_illegal = 1'b1;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  // Word accesses must be even-aligned; byte ops never trip this.
  assign reject = op_illegal || (((op == OP_LW) || (op == OP_SW)) && ea_in[0]);
`else
  assign reject = op_illegal;
`endif

  assign op_q_is_load = (op_q == OP_LW) || (op_q == OP_LBU) || (op_q == OP_LB);

  always_comb begin
    load_ext = memDataOut;
    case (op_q)
      OP_LBU:  load_ext = {{(DATA_W-8){1'b0}}, memDataOut[7:0]};
      OP_LB:   load_ext = {{(DATA_W-8){memDataOut[7]}}, memDataOut[7:0]};
      default: load_ext = memDataOut;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (reject) begin
            state_nxt = S_DONE;
          end else if (op == OP_SW) begin
            state_nxt = S_WR;
          end else begin
            // Loads and SB (read half of the read-modify-write)
            state_nxt = S_RD;
          end
        end
      end
      S_RD:    state_nxt = S_WAIT;
      S_WAIT:  state_nxt = (op_q == OP_SB) ? S_WR : S_DONE;
      S_WR:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latches, load result and RMW merge word
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= 3'b000;
      sd_q     <= '0;
      ea_q     <= '0;
      merge_q  <= '0;
      err_q    <= 1'b0;
      loadData <= '0;
    end else begin
      if (accept) begin
        op_q  <= op;
        sd_q  <= storeData;
        ea_q  <= ea_in;
        err_q <= reject;
      end
      if (state == S_WAIT) begin
        if (op_q_is_load) begin
          loadData <= load_ext;
        end
        if (op_q == OP_SB) begin
          // Keep the neighbouring byte so the two-byte write leaves it intact.
          merge_q <= {memDataOut[DATA_W-1:8], sd_q[7:0]};
        end
      end
    end
  end

  // Moore outputs. Enables are gated by rst so a reset landing on an RD/WR
  // cycle never reaches memory, which keeps an interrupted RMW harmless.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    err       = (state == S_DONE) && err_q;
    MemRd     = (state == S_RD) && !rst;
    MemWr     = (state == S_WR) && !rst;
    memAddr   = ea_q;
    memDataIn = '0;
    if (state == S_WR) begin
      memDataIn = (op_q == OP_SB) ? merge_q : sd_q;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] base = 16'h0;
  logic [15:0] offset = 16'h0;
  logic [15:0] storeData = 16'h0;
  logic [15:0] memDataOut;
  logic        busy, done, err, MemRd, MemWr;
  logic [15:0] loadData, memAddr, memDataIn;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .base       (base),
    .offset     (offset),
    .storeData  (storeData),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .loadData   (loadData),
    .memAddr    (memAddr),
    .memDataIn  (memDataIn),
    .memDataOut (memDataOut),
    .MemRd      (MemRd),
    .MemWr      (MemWr)
  );

  // Data memory the DUT talks to: two-byte write, registered two-byte read.
  bit [7:0] sim_mem [0:65535];
  always @(posedge clk) begin
    logic [15:0] a1;
    a1 = memAddr + 16'd1;
    if (MemWr) begin
      sim_mem[memAddr] <= memDataIn[7:0];
      sim_mem[a1]      <= memDataIn[15:8];
    end
    if (MemRd) memDataOut <= {sim_mem[a1], sim_mem[memAddr]};
  end

  // Reference model state
  bit [7:0]    ref_mem [0:65535];
  logic [15:0] ref_ld = 16'h0;

  int n_pass = 0;
  int n_tot  = 0;

  int          last_done_k;
  logic        last_err;
  logic [15:0] last_wdata;
  logic [15:0] last_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic garbage_inputs();
    start     = 1'b1;
    op        = 3'($urandom);
    base      = 16'($urandom);
    offset    = 16'($urandom);
    storeData = 16'($urandom);
  endtask

  // Issues one request and checks every cycle until the unit is back in IDLE.
  // Called positioned just after a clock edge with the DUT idle.
  task automatic do_req(input logic [2:0] o, input logic [15:0] b,
                        input logic [15:0] f, input logic [15:0] sd);
    logic [15:0] ea, ea1, w, nld, wd;
    logic        bad, isld, isst;
    int          lat, rdk, wrk;
    ea  = b + f;
    ea1 = ea + 16'd1;
    bad = !(o inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_ALIGN_CHECK_EN
    if ((o == 3'b000 || o == 3'b100) && ea[0]) bad = 1'b1;
`endif
    isld = !bad && (o inside {3'b000, 3'b001, 3'b010});
    isst = !bad && (o inside {3'b100, 3'b101});
    w = {ref_mem[ea1], ref_mem[ea]};
    case (o)
      3'b000:  nld = w;
      3'b001:  nld = {8'h00, w[7:0]};
      3'b010:  nld = {{8{w[7]}}, w[7:0]};
      default: nld = ref_ld;
    endcase
    wd  = (o == 3'b100) ? sd : {w[15:8], sd[7:0]};
    lat = bad ? 1 : (o == 3'b100) ? 2 : (o == 3'b101) ? 4 : 3;
    rdk = (isld || (isst && o == 3'b101)) ? 1 : 0;
    wrk = isst ? lat - 1 : 0;

    start = 1'b1; op = o; base = b; offset = f; storeData = sd;
    last_done_k = 0; last_err = 1'b0; last_wdata = 16'h0; last_addr = 16'h0;
    @(posedge clk);
    for (int k = 1; k <= lat + 1; k++) begin
      #1;
      chk("busy",      32'(busy),      32'(k <= lat));
      chk("done",      32'(done),      32'(k == lat));
      chk("err",       32'(err),       32'((k == lat) && bad));
      chk("MemRd",     32'(MemRd),     32'(k == rdk));
      chk("MemWr",     32'(MemWr),     32'(k == wrk));
      chk("memAddr",   32'(memAddr),   32'(ea));
      chk("memDataIn", 32'(memDataIn), 32'((k == wrk) ? wd : 16'h0));
      chk("loadData",  32'(loadData),  32'((isld && k >= lat) ? nld : ref_ld));
      if (done) begin last_done_k = k; last_err = err; end
      if (MemWr) last_wdata = memDataIn;
      if (k == 1) last_addr = memAddr;
      if (k < lat) garbage_inputs();
      else start = 1'b0;
      if (k <= lat) @(posedge clk);
    end
    if (isld) ref_ld = nld;
    if (isst) begin
      ref_mem[ea]  = wd[7:0];
      ref_mem[ea1] = wd[15:8];
      chk("mem_lo", 32'(sim_mem[ea]),  32'(ref_mem[ea]));
      chk("mem_hi", 32'(sim_mem[ea1]), 32'(ref_mem[ea1]));
    end
  endtask

  // SB with reset asserted during its WR cycle: no write may reach memory.
  task automatic do_sb_reset(input logic [15:0] b, input logic [15:0] f, input logic [15:0] sd);
    logic [15:0] ea, ea1;
    ea  = b + f;
    ea1 = ea + 16'd1;
    start = 1'b1; op = 3'b101; base = b; offset = f; storeData = sd;
    @(posedge clk); #1;
    chk("rst_sb_rd", 32'(MemRd), 32'd1);
    garbage_inputs();
    @(posedge clk); #1;
    chk("rst_sb_wait_busy", 32'(busy), 32'd1);
    garbage_inputs();
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b1;
    #1;
    chk("rst_wr_gate", 32'(MemWr), 32'd0);
    chk("rst_wr_busy", 32'(busy),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_loadData", 32'(loadData), 32'd0);
    chk("rst_memAddr",  32'(memAddr),  32'd0);
    ref_ld = 16'h0;
    chk("rst_mem_lo", 32'(sim_mem[ea]),  32'(ref_mem[ea]));
    chk("rst_mem_hi", 32'(sim_mem[ea1]), 32'(ref_mem[ea1]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ops [8];
    ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy",      32'(busy),      32'd0);
    chk("reset_done",      32'(done),      32'd0);
    chk("reset_err",       32'(err),       32'd0);
    chk("reset_MemRd",     32'(MemRd),     32'd0);
    chk("reset_MemWr",     32'(MemWr),     32'd0);
    chk("reset_loadData",  32'(loadData),  32'd0);
    chk("reset_memAddr",   32'(memAddr),   32'd0);
    chk("reset_memDataIn", 32'(memDataIn), 32'd0);

    // Directed sequence with hand-computed values
    do_req(3'b100, 16'h0010, 16'h0002, 16'hBEEF);
    chk("lit_sw_wdata", 32'(last_wdata), 32'h0000BEEF);
    chk("lit_sw_lat",   32'(last_done_k), 32'd2);
    chk("lit_mem12",    32'(sim_mem[16'h0012]), 32'h000000EF);
    chk("lit_mem13",    32'(sim_mem[16'h0013]), 32'h000000BE);

    do_req(3'b000, 16'h0012, 16'h0000, 16'h0000);
    chk("lit_lw",     32'(loadData), 32'h0000BEEF);
    chk("lit_lw_lat", 32'(last_done_k), 32'd3);
    do_req(3'b010, 16'h0012, 16'h0000, 16'h0000);
    chk("lit_lb", 32'(loadData), 32'h0000FFEF);
    do_req(3'b001, 16'h0012, 16'h0000, 16'h0000);
    chk("lit_lbu", 32'(loadData), 32'h000000EF);

    do_req(3'b101, 16'h0014, 16'hFFFE, 16'h0042);
    chk("lit_sb_wdata", 32'(last_wdata), 32'h0000BE42);
    chk("lit_sb_lat",   32'(last_done_k), 32'd4);
    do_req(3'b000, 16'h0012, 16'h0000, 16'h0000);
    chk("lit_lw_after_sb", 32'(loadData), 32'h0000BE42);

    do_req(3'b011, 16'h0012, 16'h0000, 16'h1234);
    chk("lit_ill_lat", 32'(last_done_k), 32'd1);
    chk("lit_ill_err", 32'(last_err), 32'd1);
    chk("lit_ill_ld",  32'(loadData), 32'h0000BE42);

    do_req(3'b001, 16'hFFFF, 16'h0002, 16'h0000);
    chk("lit_wrap_addr", 32'(last_addr), 32'h00000001);

    do_req(3'b101, 16'hFFFF, 16'h0000, 16'h005A);
    do_req(3'b001, 16'hFFFF, 16'h0000, 16'h0000);
    chk("lit_lbu_ffff", 32'(loadData), 32'h0000005A);
    chk("lit_mem_ffff", 32'(sim_mem[16'hFFFF]), 32'h0000005A);

    do_sb_reset(16'h0012, 16'h0000, 16'h0099);
    do_req(3'b000, 16'h0012, 16'h0000, 16'h0000);
    chk("lit_lw_after_rst", 32'(loadData), 32'h0000BE42);

    do_req(3'b000, 16'h0013, 16'h0000, 16'h0000);
`ifdef LSU_ALIGN_CHECK_EN
    chk("lit_align_err", 32'(last_err), 32'd1);
    chk("lit_align_lat", 32'(last_done_k), 32'd1);
    chk("lit_align_ld",  32'(loadData), 32'h0000BE42);
`else
    chk("lit_odd_lw_err", 32'(last_err), 32'd0);
    chk("lit_odd_lw_lat", 32'(last_done_k), 32'd3);
    chk("lit_odd_lw",     32'(loadData), 32'h000000BE);
`endif

    // Randomized requests in a small window around 0x0000 and 0xFFFF so
    // loads keep hitting previously stored data and the wrap is exercised.
    for (int i = 0; i < 300; i++) begin
      logic [2:0]  o;
      logic [15:0] b, f;
      int          r;
      r = $urandom_range(0, 19);
      o = (r < 17) ? ops[r % 5] : ops[5 + (r - 17)];
      b = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                       : 16'($urandom_range(0, 31));
      f = 16'($urandom_range(0, 16)) - 16'd8;
      do_req(o, b, f, 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access sequencer that sits directly upstream of the data memory in the multi-cycle core.
- Accepts one load/store request from the datapath and computes the effective address.
- Drives the memory's addr/dataIn/MemRd/MemWr, absorbs the memory's one-cycle registered read, and returns extended load data with a done pulse.
- Byte stores are done as read-modify-write, because the memory always writes two bytes (addr, addr+1).

Parameters:
- ADDR_W, 16, address width; effective-address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 16, data word width; a memory word is bytes {addr+1, addr}, little-endian.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  3  000=LW, 001=LBU, 010=LB, 100=SW, 101=SB; all other codes are illegal.
- base  in  16  base register value.
- offset  in  16  signed offset, two's complement.
- storeData  in  16  store data; SB uses only bits [7:0].
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done on an illegal or rejected request.
- loadData  out  16  result of the last completed load; held otherwise.
- memAddr  out  16  to memory addr.
- memDataIn  out  16  to memory dataIn.
- memDataOut  in  16  from memory dataOut; valid the cycle after MemRd.
- MemRd  out  1  memory read enable.
- MemWr  out  1  memory write enable.

Behaviour:
- States: IDLE, RD, WAIT, WR, DONE.
- Request capture (IDLE with start=1):
  - Latch op and storeData.
  - Latch ea = (base + offset) mod 2^16; the carry is discarded, so 16'hFFFF + 16'h0002 = 16'h0001.
  - Latching happens regardless of other inputs.
- Transitions from IDLE on start:
  - LW/LBU/LB -> RD.
  - SW -> WR.
  - SB -> RD.
  - Illegal op -> DONE with err=1, no memory access.
- RD -> WAIT.
  - MemRd=1, memAddr=ea.
  - MemRd is Moore-decoded from state.
- WAIT:
  - memDataOut is valid.
  - Loads: capture into loadData at the end of WAIT, then -> DONE.
    - LW: loadData = memDataOut.
    - LBU: loadData = {8'h00, memDataOut[7:0]}.
    - LB: loadData = {8{memDataOut[7]}, memDataOut[7:0]}.
  - SB: capture merge = {memDataOut[15:8], storeData[7:0]}, then -> WR.
- WR -> DONE.
  - MemWr=1, memAddr=ea.
  - memDataIn = storeData for SW, merge for SB.
- DONE -> IDLE unconditionally; done=1.
- Latency from the start-accept edge to the done cycle:
  - SW: 2.
  - LW/LB/LBU: 3.
  - SB: 4.
  - Illegal op: 1.
- Back-to-back requests: the next start can be accepted in the cycle after DONE. start while busy is ignored (not queued).
- MemRd and MemWr are never both 1.
- In IDLE/DONE: MemRd=MemWr=0, memAddr=ea, memDataIn=0.
- Reset:
  - rst=1 forces the state to IDLE at the next edge.
  - busy, done and err are 0 in IDLE.
  - loadData, ea and the latches clear to 0.
  - MemRd and MemWr are gated with !rst, so a WR or RD cycle that coincides with rst=1 produces no memory write or read.
  - Reset mid-RMW therefore leaves memory unmodified.
- Byte accesses at ea=16'hFFFF: memory sees a word at FFFF/0000 (its own wrap); the low byte is at FFFF.
- done and err are asserted only in DONE.

Optional Feature:
- Macro LSU_ALIGN_CHECK_EN.
- Defined:
  - LW or SW with ea[0]=1 is rejected: IDLE -> DONE with done=1, err=1, no MemRd/MemWr.
  - loadData is unchanged.
  - Byte ops are unaffected.
- Undefined: no alignment check. Odd word addresses pass through to memory as unaligned little-endian accesses, and err fires only for illegal op codes.

Test Plan:
- Reset then SW: base=0x0010, offset=0x0002, storeData=0xBEEF, op=100.
  - MemWr=1 one cycle with memAddr=0x0012, memDataIn=0xBEEF.
  - done on cycle 2; memory bytes [0x12]=EF, [0x13]=BE.
- LW at 0x0012 after the above.
  - MemRd one cycle, done on cycle 3, loadData=0xBEEF.
- LB at 0x0012 -> loadData=0xFFEF. LBU at 0x0012 -> loadData=0x00EF.
- SB: storeData=0x0042, base=0x0014, offset=0xFFFE (i.e. -2).
  - Sequence RD, WAIT, WR with memAddr=0x0012, memDataIn=0xBE42.
  - done on cycle 4; a following LW at 0x0012 returns 0xBE42.
- op=011:
  - done and err on cycle 1, MemRd=MemWr=0 throughout, loadData unchanged.
  - start asserted while busy is ignored.
- SB to 0x0012 with rst asserted during the WR cycle.
  - No MemWr pulse; the following LW returns the prior value 0xBE42.
  - busy=0 and loadData=0 after reset.
  - With LSU_ALIGN_CHECK_EN defined, LW at 0x0013 -> err=1, done on cycle 1, no MemRd.
